// File: rtl/calc_pkg.sv
// calc_multiport shared definitions.
// Command/response codes, port state and the ALU helper.
package calc_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_OK   = 2'b01;
  localparam logic [1:0] RSP_OVF  = 2'b10;
  localparam logic [1:0] RSP_INV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    PEND
  } port_state_e;

  typedef struct packed {
    logic [1:0]  resp;
    logic [63:0] res;
  } alu_out_t;

  // Operands arrive zero-extended to 64 bits; w is the live width.
  function automatic alu_out_t alu_op(
    input logic [3:0]  cmd,
    input logic [63:0] op1,
    input logic [63:0] op2,
    input int unsigned w
  );
    logic [64:0] sum;
    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  sh;
    alu_out_t    o;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = op1 & mask;
    b    = op2 & mask;
    sh   = op2[5:0] & 6'(w - 1);
    sum  = {1'b0, a} + {1'b0, b};
    o.resp = RSP_OK;
    o.res  = '0;
    unique case (1'b1)
      (cmd == CMD_ADD): begin
        if (sum[w]) o.resp = RSP_OVF;
        else o.res = sum[63:0] & mask;
      end
      (cmd == CMD_SUB): begin
        if (b > a) o.resp = RSP_OVF;
        else o.res = (a - b) & mask;
      end
      (cmd == CMD_SHL): o.res = (a << sh) & mask;
      (cmd == CMD_SHR): o.res = a >> sh;
      default: o.resp = RSP_INV;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// Round-robin arbiter for calc_multiport.
// One-hot grant, pointer moves past the winner.
module calc_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         c_clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          hit;

  // Search from the pointer with wrap, first requester wins.
  always_comb begin
    gnt   = '0;
    hit   = 1'b0;
    ptr_d = ptr_q;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!hit && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = PW'((int'(ptr_q) + i + 1) % N);
      end
    end
  end

  // Pointer holds when nobody is granted.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else if (hit) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/calc_multiport.sv
// Multi-port calculator: per-port command FSMs sharing
// one registered ALU through a round-robin arbiter.
module calc_multiport
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 32
) (
  input  logic                       c_clk,
  input  logic                       reset_n,
  input  logic [4*NUM_PORTS-1:0]     cmd_in,
  input  logic [WIDTH*NUM_PORTS-1:0] data_in,
  output logic [NUM_PORTS-1:0]       busy_out,
  output logic [2*NUM_PORTS-1:0]     resp_out,
  output logic [WIDTH*NUM_PORTS-1:0] data_out
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic [3:0]           cmd_a [NUM_PORTS];
  logic [WIDTH-1:0]     op1_a [NUM_PORTS];
  logic [WIDTH-1:0]     op2_a [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_state_e      st_q;
    port_state_e      st_d;
    logic [3:0]       cmd_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic             busy_p;
    logic [3:0]       cmd_p;
    logic [WIDTH-1:0] data_p;

    assign cmd_p  = cmd_in[4*p +: 4];
    assign data_p = data_in[WIDTH*p +: WIDTH];

    // State and operand capture.
    always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q  <= IDLE;
        cmd_q <= CMD_NOP;
        op1_q <= '0;
        op2_q <= '0;
      end else begin
        st_q <= st_d;
        if (st_q == IDLE && cmd_p != CMD_NOP) begin
          cmd_q <= cmd_p;
          op1_q <= data_p;
        end
        if (st_q == OP2) op2_q <= data_p;
      end
    end

    // Next state: commands only enter from IDLE.
    always_comb begin
      st_d = st_q;
      unique case (st_q)
        IDLE:    if (cmd_p != CMD_NOP) st_d = OP2;
        OP2:     st_d = PEND;
        PEND:    if (gnt[p]) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end

    // Busy while waiting for the ALU.
    always_comb busy_p = (st_q == PEND);

    assign busy_out[p] = busy_p;
    assign req[p]      = busy_p;
    assign cmd_a[p]    = cmd_q;
    assign op1_a[p]    = op1_q;
    assign op2_a[p]    = op2_q;
  end

  calc_rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .c_clk   (c_clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  logic [3:0]       cmd_sel;
  logic [WIDTH-1:0] op1_sel;
  logic [WIDTH-1:0] op2_sel;
  logic [PW-1:0]    gnt_idx;
  alu_out_t         alu_r;
  logic             unused_alu_hi;

  // Route the granted port's operands into the ALU.
  always_comb begin
    cmd_sel = CMD_NOP;
    op1_sel = '0;
    op2_sel = '0;
    gnt_idx = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        cmd_sel = cmd_a[p];
        op1_sel = op1_a[p];
        op2_sel = op2_a[p];
        gnt_idx = PW'(p);
      end
    end
  end

  // Shared ALU evaluation.
  always_comb alu_r = alu_op(cmd_sel, 64'(op1_sel), 64'(op2_sel), WIDTH);

  assign unused_alu_hi = ^alu_r.res;

  logic             alu_v;
  logic [PW-1:0]    alu_idx;
  logic [1:0]       alu_resp;
  logic [WIDTH-1:0] alu_res;

  // Registered result tagged with the owning port.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_v    <= 1'b0;
      alu_idx  <= '0;
      alu_resp <= RSP_NONE;
      alu_res  <= '0;
    end else begin
      alu_v <= |gnt;
      if (|gnt) begin
        alu_idx  <= gnt_idx;
        alu_resp <= alu_r.resp;
        alu_res  <= alu_r.res[WIDTH-1:0];
      end
    end
  end

  // Fan the result out to the owning port only.
  always_comb begin
    resp_out = '0;
    data_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (alu_v && alu_idx == PW'(p)) begin
        resp_out[2*p +: 2]         = alu_resp;
        data_out[WIDTH*p +: WIDTH] = alu_res;
      end
    end
  end

endmodule

// File: tb/tb_calc_multiport.sv
// Scoreboard bench for calc_multiport.
// Random and directed traffic against a behavioural model.
module tb_calc_multiport;

  localparam int NP = 4;
  localparam int W  = 32;

  typedef struct {
    logic [1:0]  r;
    logic [31:0] d;
    int          lat;
  } exp_t;

  logic            c_clk = 1'b0;
  logic            reset_n;
  logic [4*NP-1:0] cmd_in;
  logic [W*NP-1:0] data_in;
  logic [NP-1:0]   busy_out;
  logic [2*NP-1:0] resp_out;
  logic [W*NP-1:0] data_out;

  logic [7:0]  s_cmd;
  logic [15:0] s_data;
  logic [1:0]  s_busy;
  logic [3:0]  s_resp;
  logic [15:0] s_dout;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  int          pstate    [NP];
  int          issue_cyc [NP];
  logic [31:0] op2_hold  [NP];
  exp_t        q [NP][$];

  calc_multiport #(.NUM_PORTS(NP), .WIDTH(W)) dut (
    .c_clk    (c_clk),
    .reset_n  (reset_n),
    .cmd_in   (cmd_in),
    .data_in  (data_in),
    .busy_out (busy_out),
    .resp_out (resp_out),
    .data_out (data_out)
  );

  calc_multiport #(.NUM_PORTS(2), .WIDTH(8)) dut_s (
    .c_clk    (c_clk),
    .reset_n  (reset_n),
    .cmd_in   (s_cmd),
    .data_in  (s_data),
    .busy_out (s_busy),
    .resp_out (s_resp),
    .data_out (s_dout)
  );

  always #5 c_clk = ~c_clk;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", n, got, exp);
  endtask

  function automatic logic [33:0] ref_calc(logic [3:0] c,
                                           logic [31:0] a,
                                           logic [31:0] b);
    longint unsigned s;
    case (c)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s > 64'hFFFF_FFFF) return {2'b10, 32'h0};
        return {2'b01, s[31:0]};
      end
      4'd2: begin
        if (b > a) return {2'b10, 32'h0};
        return {2'b01, a - b};
      end
      4'd5: return {2'b01, a << (b % 32)};
      4'd6: return {2'b01, a >> (b % 32)};
      default: return {2'b11, 32'h0};
    endcase
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_cmd();
    case ($urandom_range(0, 4))
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd5;
      3: return 4'd6;
      default: return 4'($urandom_range(1, 15));
    endcase
  endfunction

  task automatic issue(int p, logic [3:0] c, logic [31:0] a,
                       logic [31:0] b, int lat);
    exp_t        e;
    logic [33:0] rv;
    rv = ref_calc(c, a, b);
    e.r   = rv[33:32];
    e.d   = rv[31:0];
    e.lat = lat;
    q[p].push_back(e);
    cmd_in[4*p +: 4]   = c;
    data_in[32*p +: 32] = a;
    op2_hold[p]  = b;
    issue_cyc[p] = cyc;
    pstate[p]    = 1;
  endtask

  // Advance one cycle; second operand and junk commands are automatic.
  task automatic tick();
    @(negedge c_clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      case (pstate[p])
        1: begin
          cmd_in[4*p +: 4]    = 4'($urandom_range(1, 15));
          data_in[32*p +: 32] = op2_hold[p];
          pstate[p] = 2;
        end
        2: begin
          cmd_in[4*p +: 4]    = 4'($urandom_range(1, 15));
          data_in[32*p +: 32] = $urandom;
        end
        default: begin
          cmd_in[4*p +: 4]    = 4'd0;
          data_in[32*p +: 32] = $urandom;
        end
      endcase
    end
  endtask

  task automatic wait_idle(int p);
    int n = 0;
    while (pstate[p] != 0 && n < 40) begin
      tick();
      n++;
    end
    if (pstate[p] != 0) begin
      total++;
      $display("FAIL timeout port %0d: still waiting, expected response", p);
      pstate[p] = 0;
      q[p].delete();
    end
  endtask

  task automatic wait_all();
    for (int p = 0; p < NP; p++) wait_idle(p);
  endtask

  task automatic flush();
    for (int p = 0; p < NP; p++) begin
      q[p].delete();
      pstate[p] = 0;
    end
    cmd_in = '0;
  endtask

  // Monitor: pop and compare whenever a port presents a response.
  always @(negedge c_clk) begin
    logic [1:0]  r;
    logic [31:0] d;
    exp_t        e;
    int          lat;
    if (reset_n) begin
      for (int p = 0; p < NP; p++) begin
        r = resp_out[2*p +: 2];
        d = data_out[32*p +: 32];
        if (r == 2'b00) begin
          chk($sformatf("idle_data p%0d", p), d, 0);
        end else if (q[p].size() == 0) begin
          total++;
          $display("FAIL unexpected_resp p%0d: got resp %0d, expected none",
                   p, r);
        end else begin
          e   = q[p].pop_front();
          lat = cyc - issue_cyc[p] - 1;
          chk($sformatf("resp p%0d", p), r, e.r);
          chk($sformatf("data p%0d", p), d, e.d);
          if (e.lat > 0) begin
            chk($sformatf("latency p%0d", p), lat, e.lat);
          end else begin
            total++;
            if (lat >= 2 && lat <= NP + 1) passed++;
            else $display("FAIL latency_range p%0d: got %0d, expected 2..%0d",
                          p, lat, NP + 1);
          end
          pstate[p] = 0;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    cmd_in  = '0;
    data_in = '0;
    s_cmd   = '0;
    s_data  = '0;
    flush();
    repeat (2) @(negedge c_clk);
    #1;
    chk("rst_busy", busy_out, 0);
    chk("rst_resp", resp_out, 0);
    chk("rst_data", data_out, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", busy_out, 0);
    chk("post_rst_resp", resp_out, 0);

    // Two contention waves, pointer starts at 0 each time.
    for (int w = 0; w < 2; w++) begin
      for (int p = 0; p < NP; p++) issue(p, 4'd1, p, p, 2 + p);
      wait_all();
    end

    // Uncontended add on port 0 with busy window.
    issue(0, 4'd1, 32'd5, 32'd7, 2);
    tick();
    chk("busy_op2", busy_out, 4'b0000);
    tick();
    chk("busy_pend", busy_out, 4'b0001);
    wait_idle(0);
    chk("busy_done", busy_out, 4'b0000);

    // Overflow / underflow on port 1.
    issue(1, 4'd1, 32'hFFFF_FFFF, 32'd1, 2);
    wait_idle(1);
    issue(1, 4'd2, 32'd3, 32'd4, 2);
    wait_idle(1);
    issue(1, 4'd2, 32'd4, 32'd3, 2);
    wait_idle(1);

    // Shifts and an invalid code on port 2.
    issue(2, 4'd5, 32'd1, 32'd31, 2);
    wait_idle(2);
    issue(2, 4'd6, 32'h8000_0000, 32'd35, 2);
    wait_idle(2);
    issue(2, 4'd3, 32'd9, 32'd9, 2);
    wait_idle(2);

    // Back-to-back on port 3, issued in its response cycle.
    issue(3, 4'd1, 32'd10, 32'd20, 2);
    wait_idle(3);
    issue(3, 4'd2, 32'd9, 32'd4, 2);
    wait_idle(3);

    // Reset while three ports are pending.
    issue(0, 4'd1, 32'd1, 32'd2, 0);
    issue(1, 4'd2, 32'd8, 32'd2, 0);
    issue(2, 4'd5, 32'd3, 32'd4, 0);
    tick();
    tick();
    chk("pend3_busy", busy_out, 4'b0111);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy_out, 0);
    chk("midrst_resp", resp_out, 0);
    chk("midrst_data", data_out, 0);
    flush();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();

    // Random traffic.
    repeat (400) begin
      tick();
      for (int p = 0; p < NP; p++)
        if (pstate[p] == 0 && $urandom_range(0, 2) == 0)
          issue(p, rand_cmd(), rand_op(), rand_op(), 0);
    end
    wait_all();
    repeat (5) tick();
    for (int p = 0; p < NP; p++)
      chk($sformatf("queue_empty p%0d", p), q[p].size(), 0);

    // Narrow instance: 8-bit, two ports.
    s_cmd  = 8'h01;
    s_data = 16'h00C8;
    tick();
    s_cmd  = 8'h00;
    s_data = 16'h0064;
    tick();
    chk("s_busy", s_busy, 2'b01);
    tick();
    chk("s_ovf_resp", s_resp, 4'b0010);
    chk("s_ovf_data", s_dout, 16'h0000);
    s_cmd  = 8'h10;
    s_data = 16'h6400;
    tick();
    s_cmd  = 8'h00;
    s_data = 16'h1B00;
    tick();
    tick();
    chk("s_add_resp", s_resp, 4'b0100);
    chk("s_add_data", s_dout, 16'h7F00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
